// File: rtl/sd_dma_sink_if.sv
// ---------------------------------------------------------------------------
// sd_dma_sink_if
//
// Wishbone B3 classic bundle between the sdc_controller DMA master port
// (m_wb_*) and the sd_dma_sink slave. Signal names are given from the
// slave's point of view, so the *_i signals are driven by the master.
//
// Signals:
//   wb_adr_i [31:0]  DMA address (master -> slave)
//   wb_dat_i [31:0]  write data (master -> slave)
//   wb_dat_o [31:0]  read data (slave -> master)
//   wb_sel_i [3:0]   byte select (master -> slave)
//   wb_we_i          write enable (master -> slave)
//   wb_cyc_i         bus cycle (master -> slave)
//   wb_stb_i         strobe (master -> slave)
//   wb_ack_o         acknowledge (slave -> master)
//
// Modports: master (controller side), slave (sink side).
// ---------------------------------------------------------------------------
interface sd_dma_sink_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sd_dma_sink.sv
// ---------------------------------------------------------------------------
// sd_dma_sink
//
// Wishbone B3 classic slave that terminates the SD controller's DMA master
// port. Read-block data words written by the controller are buffered in a
// word FIFO, then unpacked into a byte stream (valid/ready) for the frame
// decoder. A one-cycle block_done pulse marks every BLOCK_WORDS accepted
// words so sd_bus_master can issue the next read command.
//
// Parameters:
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 32-bit words (>= 1)
//   BLOCK_WORDS  words per SD block, 1..65535 (128 words = 512 bytes)
//
// Ports:
//   clk         system / Wishbone clock
//   reset       asynchronous active-high reset
//   wb          Wishbone slave bundle (sd_dma_sink_if.slave)
//   flush       synchronous clear of FIFO, unpacker and block counter
//   out_data    current byte of the holding register
//   out_valid   out_data valid
//   out_ready   consumer accepts the byte when high together with out_valid
//   block_done  one-cycle pulse on the ack of the last word of a block
//   fifo_level  words in the FIFO (the holding register is not counted)
//
// Build option:
//   SD_DMA_SINK_LSB_FIRST_EN  when defined, bytes leave LSB first
//                             ([7:0] first); otherwise MSB first
//                             ([31:24] first).
// ---------------------------------------------------------------------------
module sd_dma_sink #(
  parameter int DEPTH_LOG2  = 4,
  parameter int BLOCK_WORDS = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  sd_dma_sink_if.slave          wb,
  input  logic                  flush,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  block_done,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]       BLK_LAST  = 16'(BLOCK_WORDS - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } hold_state_e;

  // Bus side
  logic                  ack_q, ack_d;
  logic                  req;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  push;

  // FIFO
  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  // Holding register / unpacker
  hold_state_e           state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           hold_q, hold_d;

  // Block counter
  logic [15:0]           blk_q, blk_d;
  logic                  done_q, done_d;

  // Address and byte selects carry no information for this sink; the full
  // word is always stored.
  logic                  unused_ok;
  assign unused_ok = ^{wb.wb_adr_i, wb.wb_sel_i};

  // Selects byte i of a word in emission order.
  function automatic logic [7:0] sel_byte(input logic [31:0] w,
                                          input logic [1:0]  i);
    logic [4:0]  sh;
    logic [31:0] tmp;
`ifdef SD_DMA_SINK_LSB_FIRST_EN
    sh = {i, 3'b000};
`else
    sh = {~i, 3'b000};
`endif
    tmp = w >> sh;
    return tmp[7:0];
  endfunction

  // -------------------------------------------------------------------------
  // Wishbone request decode
  // -------------------------------------------------------------------------
  assign fifo_full  = (cnt_q == DEPTH_CNT);
  assign fifo_empty = (cnt_q == '0);

  // Masking with ack_q enforces the two-clock minimum per access: the
  // master still holds stb during the ack cycle.
  assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_acc = req & wb.wb_we_i & ~fifo_full;
  assign rd_acc = req & ~wb.wb_we_i;
  assign ack_d  = wr_acc | rd_acc;

  // A write accepted during flush is acked but its data is dropped.
  assign push   = wr_acc & ~flush;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = '0;

  // -------------------------------------------------------------------------
  // Unpacker next state. The holding register only loads from the FIFO, so
  // a word pushed into an empty FIFO appears one edge later.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            hold_d  = mem_q[rd_ptr_q];
            state_d = ST_HOLD;
            idx_d   = 2'd0;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (idx_q != 2'd3) begin
              idx_d = idx_q + 2'd1;
            end else if (!fifo_empty) begin
              // Reload on the last byte so the stream has no bubble.
              pop    = 1'b1;
              hold_d = mem_q[rd_ptr_q];
              idx_d  = 2'd0;
            end else begin
              state_d = ST_EMPTY;
              idx_d   = 2'd0;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Block counter: the pulse is registered alongside the ack of the word
  // that completes the block.
  // -------------------------------------------------------------------------
  always_comb begin
    blk_d  = blk_q;
    done_d = 1'b0;
    if (flush) begin
      blk_d = '0;
    end else if (push) begin
      if (blk_q == BLK_LAST) begin
        blk_d  = '0;
        done_d = 1'b1;
      end else begin
        blk_d = blk_q + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wb.wb_dat_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_EMPTY;
      idx_q    <= 2'd0;
      hold_q   <= '0;
      blk_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      blk_q    <= blk_d;
      done_q   <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid  = (state_q == ST_HOLD);
  assign out_data   = sel_byte(hold_q, idx_q);
  assign block_done = done_q;
  assign fifo_level = cnt_q;

endmodule

// File: tb/tb_sd_dma_sink.sv
// ---------------------------------------------------------------------------
// tb_sd_dma_sink
//
// Self-checking bench for sd_dma_sink. A byte queue holds the stream the
// sink must emit (every acked, unflushed write contributes four bytes in
// emission order); a word counter models block boundaries. Inputs change
// 1 ns after the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sd_dma_sink;
  localparam int DEPTH_LOG2  = 4;
  localparam int BLOCK_WORDS = 128;

  logic                clk;
  logic                reset;
  logic                flush;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic                block_done;
  logic [DEPTH_LOG2:0] fifo_level;

  logic man_ready;
  logic rnd_ready;
  logic rnd_bit;
  assign out_ready = rnd_ready ? rnd_bit : man_ready;

  sd_dma_sink_if bus ();

  sd_dma_sink #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb         (bus),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .block_done (block_done),
    .fifo_level (fifo_level)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  int         wcnt = 0;
  int         bd_pulses = 0;
  int         bd_orphan = 0;
  int         ack_long = 0;
  logic       ack_prev = 1'b0;
  logic [8:0] mon_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected stream bytes for one word, in emission order.
  task automatic model_push(input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
`ifdef SD_DMA_SINK_LSB_FIRST_EN
      exp_q.push_back({1'b0, d[8*k +: 8]});
`else
      exp_q.push_back({1'b0, d[8*(3-k) +: 8]});
`endif
    end
  endtask

  // Stream monitor and pulse bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      if (block_done) begin
        bd_pulses++;
        if (!bus.wb_ack_o) bd_orphan++;
      end
      if (bus.wb_ack_o && ack_prev) ack_long++;
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
        else                  mon_exp = 9'h100;
        check("stream_byte", {24'd0, out_data}, {23'd0, mon_exp});
      end
    end
    ack_prev = bus.wb_ack_o;
  end

  task automatic wb_start(input logic we, input logic [31:0] d);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_dat_i = d;
    bus.wb_adr_i = $urandom;
    bus.wb_sel_i = 4'hF;
  endtask

  task automatic wb_end();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  // Waits for ack; on ack, updates the model and checks the side outputs.
  task automatic wb_wait(input int budget, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.wb_ack_o) got = 1'b1;
    end
    if (got) begin
      if (bus.wb_we_i) begin
        if (flush) begin
          wcnt = 0;
          check("bd_on_flush", block_done, 0);
        end else begin
          model_push(bus.wb_dat_i);
          wcnt++;
          if (wcnt == BLOCK_WORDS) begin
            wcnt = 0;
            check("block_done", block_done, 1);
          end else begin
            check("block_done", block_done, 0);
          end
        end
      end else begin
        check("rd_dat_o", bus.wb_dat_o, 0);
        check("bd_on_read", block_done, 0);
      end
    end
  endtask

  task automatic wb_write(input logic [31:0] d, input int budget,
                          output int n);
    bit got;
    wb_start(1'b1, d);
    wb_wait(budget, got, n);
    wb_end();
    check("wr_ack", got, 1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    rnd_ready = 1'b0;
    man_ready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid && fifo_level == 0) done = 1'b1;
    end
    check("drain_done", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   bus.wb_ack_o, 0);
    check({tag, "_dat_o"}, bus.wb_dat_o, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_bd"},    block_done, 0);
    check({tag, "_level"}, fifo_level, 0);
  endtask

  initial begin
    int  n;
    bit  got;
    int  vcnt;
    int  bd0;
    logic [31:0] d;

    reset = 1'b1;
    flush = 1'b0;
    man_ready = 1'b0;
    rnd_ready = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_dat_i = '0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write, consumer always ready
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_write(32'hA1B2C3D4, 10, n);
    check("wr_latency", n, 1);
    @(negedge clk);
    check("single_valid0", out_valid, 0);
    check("single_level1", fifo_level, 1);
    @(negedge clk);
    check("single_valid1", out_valid, 1);
`ifdef SD_DMA_SINK_LSB_FIRST_EN
    check("single_first", out_data, 8'hD4);
`else
    check("single_first", out_data, 8'hA1);
`endif
    vcnt = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("single_4cycles", vcnt, 4);
    check("single_level0", fifo_level, 0);

    // Back-pressure: 17 words fill holding register + FIFO, 18th stalls
    man_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) wb_write(32'h1000_0000 + i * 32'h0101_0101, 20, n);
    wb_start(1'b1, 32'hCAFE_0012);
    wb_wait(10, got, n);
    check("stall_no_ack", got, 0);
    check("stall_level", fifo_level, 16);
    check("stall_valid", out_valid, 1);
    man_ready = 1'b1;
    wb_wait(12, got, n);
    wb_end();
    check("stall_ack", got, 1);
    check("stall_ack_soon", (n <= 9), 1);
    drain(400);

    // Block boundaries: counter cleared by flush, then 256 words
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wcnt = 0;
    bd0 = bd_pulses;
    rnd_ready = 1'b1;
    for (int i = 0; i < 256; i++) wb_write(32'(i + 1), 100, n);
    drain(400);
    check("block_pulses", bd_pulses - bd0, 2);

    // Read cycle from idle
    @(posedge clk);
    #1;
    wb_start(1'b0, $urandom);
    wb_wait(5, got, n);
    wb_end();
    check("rd_ack", got, 1);
    check("rd_latency", n, 1);
    @(negedge clk);
    check("rd_level", fifo_level, 0);
    check("rd_valid", out_valid, 0);

    // Flush with 3 words buffered and a 4th write on the flush edge
    man_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) wb_write(32'h5500_0000 + 32'(i), 20, n);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_flush_valid", out_valid, 1);
    check("pre_flush_level", fifo_level, 2);
    @(posedge clk);
    #1;
    flush = 1'b1;
    wb_start(1'b1, 32'hDEAD_BEEF);
    wb_wait(5, got, n);
    wb_end();
    flush = 1'b0;
    exp_q.delete();
    wcnt = 0;
    check("flush_wr_ack", got, 1);
    @(negedge clk);
    check("flush_level", fifo_level, 0);
    check("flush_valid", out_valid, 0);
    man_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("flush_no_output", vcnt, 0);

    // Randomized traffic against the model
    rnd_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 9) == 0) begin
        wb_start(1'b0, $urandom);
        wb_wait(10, got, n);
        wb_end();
        check("rnd_rd_ack", got, 1);
      end else begin
        d = $urandom;
        wb_write(d, 200, n);
      end
    end
    drain(1000);
    check("ack_one_cycle", ack_long, 0);
    check("bd_with_ack", bd_orphan, 0);

    // Asynchronous reset while an ack is outstanding
    man_ready = 1'b0;
    @(posedge clk);
    #1;
    wb_start(1'b1, 32'h0BAD_F00D);
    @(posedge clk);
    #1;
    check("pre_rst_ack", bus.wb_ack_o, 1);
    reset = 1'b1;
    #1;
    check("async_rst_ack", bus.wb_ack_o, 0);
    wb_end();
    exp_q.delete();
    wcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
